// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle between the EX-stage issue logic and the RV32M unit.
//   master: issue side  -> drives flush, in_valid, func3, operand1/2, out_ready
//   slave : muldiv unit -> drives in_ready, out_valid, result, busy
interface rv_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        func3;
    logic [XLEN-1:0]   operand1;
    logic [XLEN-1:0]   operand2;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result;
    logic              busy;

    modport master (
        output flush, in_valid, func3, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, func3, operand1, operand2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// One operation at a time: radix-2 shift-add multiply or restoring divide on
// unsigned magnitudes over XLEN cycles, then a single sign-fix cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of rv_muldiv_unit_if (flush, request handshake,
//          result handshake, busy)
module rv_muldiv_unit #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    rv_muldiv_unit_if.slave     bus
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        func3_q;
    logic [XLEN-1:0]   op_q;       // multiplicand (mul) or divisor (div) magnitude
    logic [AW-1:0]     acc_q;      // {hi, lo}: product, or {remainder, quotient}
    logic              neg_q;      // negate the selected result in FIX
    logic [XLEN-1:0]   result_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    // Request decode: signedness, magnitudes, early-out detection
    logic              sgn1_c;
    logic              sgn2_c;
    logic [XLEN-1:0]   mag1_c;
    logic [XLEN-1:0]   mag2_c;
    logic              div_zero_c;
    logic              div_ovf_c;
    logic              early_c;
    logic [XLEN-1:0]   early_res_c;
    logic              neg_c;

    always_comb begin
        // op1 is signed for MUL/MULH/MULHSU/DIV/REM; op2 for MUL/MULH/DIV/REM
        sgn1_c = bus.operand1[XLEN-1] &
                 (bus.func3[2] ? ~bus.func3[0] : (bus.func3[1:0] != 2'b11));
        sgn2_c = bus.operand2[XLEN-1] &
                 (bus.func3[2] ? ~bus.func3[0] : ~bus.func3[1]);
        mag1_c = sgn1_c ? (~bus.operand1 + XLEN'(1)) : bus.operand1;
        mag2_c = sgn2_c ? (~bus.operand2 + XLEN'(1)) : bus.operand2;

        div_zero_c = (bus.operand2 == '0);
        div_ovf_c  = bus.func3[2] & ~bus.func3[0] &
                     (bus.operand1 == MOST_NEG) & (&bus.operand2);
        early_c    = EARLY_OUT & bus.func3[2] & (div_zero_c | div_ovf_c);

        if (div_zero_c) begin
            early_res_c = bus.func3[1] ? bus.operand1 : '1;
        end else begin
            early_res_c = bus.func3[1] ? '0 : bus.operand1;
        end

        // Remainder follows the dividend; a zero divisor leaves the quotient
        // at all ones regardless of operand signs.
        if (bus.func3[2] & bus.func3[1]) begin
            neg_c = sgn1_c;
        end else begin
            neg_c = (sgn1_c ^ sgn2_c) & ~(bus.func3[2] & div_zero_c);
        end
    end

    // One multiply or divide iteration
    logic [XLEN:0]     mul_sum_c;
    logic [XLEN:0]     div_diff_c;
    logic [AW-1:0]     acc_d;

    always_comb begin
        mul_sum_c  = {1'b0, acc_q[AW-1:XLEN]} +
                     (acc_q[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});
        div_diff_c = {acc_q[AW-1:XLEN], acc_q[XLEN-1]} - {1'b0, op_q};
        if (func3_q[2]) begin
            if (!div_diff_c[XLEN]) begin
                acc_d = {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[AW-2:XLEN], acc_q[XLEN-1], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum_c, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix and result select
    logic [AW-1:0]     prod_c;
    logic [XLEN-1:0]   quo_c;
    logic [XLEN-1:0]   rem_c;
    logic [XLEN-1:0]   fix_res_c;

    always_comb begin
        prod_c = neg_q ? (~acc_q + AW'(1)) : acc_q;
        quo_c  = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
        rem_c  = neg_q ? (~acc_q[AW-1:XLEN] + XLEN'(1)) : acc_q[AW-1:XLEN];
        case (func3_q)
            3'b000:                 fix_res_c = prod_c[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_c = prod_c[AW-1:XLEN];
            3'b100, 3'b101:         fix_res_c = quo_c;
            default:                fix_res_c = rem_c;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            func3_q     <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else if (bus.flush) begin
            // Kill wins over accept and over the result handshake
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        func3_q    <= bus.func3;
                        neg_q      <= neg_c;
                        op_q       <= bus.func3[2] ? mag2_c : mag1_c;
                        acc_q      <= {{XLEN{1'b0}}, (bus.func3[2] ? mag1_c : mag2_c)};
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (early_c) begin
                            result_q    <= early_res_c;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q   <= CW'(XLEN - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    result_q    <= fix_res_c;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (XLEN=32, EARLY_OUT=1): directed
// literal cases, handshake/flush/reset scenarios and a randomized run, all
// compared every cycle against a transaction-level reference model.
module tb_rv_muldiv_unit;

    localparam int unsigned XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rv_muldiv_unit_if #(.XLEN(XLEN)) mif ();

    rv_muldiv_unit #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
        return f3[2] && ((b == 0) ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Transaction-level model: idle / busy for a fixed latency / holding result
    typedef enum {M_IDLE, M_BUSY, M_DONE} mst_e;
    mst_e        m_st   = M_IDLE;
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res  = '0;
    logic        m_ov   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_ov = 1'b0; m_res = '0; m_left = 0;
        end else if (mif.flush) begin
            m_st = M_IDLE; m_ov = 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (mif.in_valid) begin
                    m_pend = ref_op(mif.func3, mif.operand1, mif.operand2);
                    if (is_early(mif.func3, mif.operand1, mif.operand2)) begin
                        m_st = M_DONE; m_ov = 1'b1; m_res = m_pend;
                    end else begin
                        m_st = M_BUSY; m_left = XLEN + 1;
                    end
                end
                M_BUSY: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_st = M_DONE; m_ov = 1'b1; m_res = m_pend;
                    end
                end
                default: if (mif.out_ready) begin
                    m_st = M_IDLE; m_ov = 1'b0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("out_valid", 32'(mif.out_valid), 32'(m_ov));
        chk("busy", 32'(mif.busy), 32'(m_st != M_IDLE));
        chk("result", mif.result, m_res);
        if (rst_n) chk("in_ready", 32'(mif.in_ready), 32'(m_st == M_IDLE));
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with out_ready high; check latency (edges after accept) and value
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int k;
        @(negedge clk);
        mif.in_valid = 1'b1; mif.func3 = f3; mif.operand1 = a; mif.operand2 = b;
        mif.out_ready = 1'b1; mif.flush = 1'b0;
        @(negedge clk);
        mif.in_valid = 1'b0; mif.func3 = 3'($urandom);
        mif.operand1 = $urandom; mif.operand2 = $urandom;
        k = 0;
        while (mif.out_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, " latency"}, 32'(k), 32'(exp_lat));
        chk({name, " value"}, mif.result, exp_res);
        @(negedge clk);
        chk({name, " back to idle"}, 32'(mif.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int k;
        int seen;

        mif.flush = 1'b0; mif.in_valid = 1'b0; mif.func3 = '0;
        mif.operand1 = '0; mif.operand2 = '0; mif.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 32'(mif.in_ready), 32'd1);
        chk("reset out_valid", 32'(mif.out_valid), 32'd0);
        chk("reset busy", 32'(mif.busy), 32'd0);
        chk("reset result", mif.result, 32'd0);

        // Literal cases
        run_op("MUL 7*-3",   3'd0, 32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULH",       3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("MULHSU",     3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("MULHU",      3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);
        run_op("DIV -7/2",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("REM -7/2",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("DIVU",       3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33);
        run_op("REMU 100/7", 3'd7, 32'd100,        32'd7,         32'd2,         33);
        run_op("DIVU 5/0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("REMU 5/0",   3'd7, 32'd5,          32'd0,         32'd5,         0);
        run_op("DIV ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("REM ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        run_op("DIV -5/0",   3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 0);
        run_op("REM -5/0",   3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 0);

        // Backpressure: result held, no accept while holding
        @(negedge clk);
        mif.in_valid = 1'b1; mif.func3 = 3'd3; mif.operand1 = $urandom; mif.operand2 = $urandom;
        mif.out_ready = 1'b0;
        @(negedge clk);
        mif.in_valid = 1'b0;
        k = 0;
        while (mif.out_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("bp latency", 32'(k), 32'd33);
        held = mif.result;
        for (int i = 0; i < 10; i++) begin
            mif.in_valid = 1'b1; mif.func3 = 3'd0;
            mif.operand1 = $urandom; mif.operand2 = $urandom;
            @(negedge clk);
            chk("bp result stable", mif.result, held);
            chk("bp out_valid held", 32'(mif.out_valid), 32'd1);
            chk("bp in_ready low", 32'(mif.in_ready), 32'd0);
        end
        mif.in_valid = 1'b0; mif.out_ready = 1'b1;
        @(negedge clk);
        chk("bp released out_valid", 32'(mif.out_valid), 32'd0);
        chk("bp released in_ready", 32'(mif.in_ready), 32'd1);
        mif.in_valid = 1'b1; mif.func3 = 3'd5; mif.operand1 = 32'd100; mif.operand2 = 32'd7;
        @(negedge clk);
        mif.in_valid = 1'b0;
        chk("bp next op accepted", 32'(mif.busy), 32'd1);
        k = 0;
        while (mif.out_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("bp next op value", mif.result, 32'd14);
        @(negedge clk);

        // Flush mid-calculation
        mif.in_valid = 1'b1; mif.func3 = 3'd4; mif.operand1 = $urandom; mif.operand2 = 32'd3;
        @(negedge clk);
        mif.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        mif.flush = 1'b1;
        @(negedge clk);
        mif.flush = 1'b0;
        chk("flush calc busy", 32'(mif.busy), 32'd0);
        chk("flush calc in_ready", 32'(mif.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.out_valid === 1'b1) seen = 1;
        end
        chk("flush calc no result", 32'(seen), 32'd0);

        // Flush coincident with a request
        mif.in_valid = 1'b1; mif.flush = 1'b1; mif.func3 = 3'd0;
        mif.operand1 = $urandom; mif.operand2 = $urandom;
        @(negedge clk);
        mif.in_valid = 1'b0; mif.flush = 1'b0;
        chk("flush+req busy", 32'(mif.busy), 32'd0);
        chk("flush+req in_ready", 32'(mif.in_ready), 32'd1);
        chk("flush+req out_valid", 32'(mif.out_valid), 32'd0);

        // Asynchronous reset mid-calculation
        mif.in_valid = 1'b1; mif.func3 = 3'd1; mif.operand1 = $urandom; mif.operand2 = $urandom;
        @(negedge clk);
        mif.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(mif.out_valid), 32'd0);
        chk("async rst busy", 32'(mif.busy), 32'd0);
        chk("async rst result", mif.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after rst in_ready", 32'(mif.in_ready), 32'd1);

        // Randomized traffic with backpressure and occasional flushes
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            mif.in_valid  = ($urandom_range(0, 9) < 6);
            mif.func3     = 3'($urandom);
            mif.operand1  = pick();
            mif.operand2  = pick();
            mif.out_ready = ($urandom_range(0, 9) < 7);
            mif.flush     = ($urandom_range(0, 199) == 0);
        end
        mif.in_valid = 1'b0; mif.flush = 1'b0; mif.out_ready = 1'b1;
        repeat (50) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
